// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared definitions for the LC-3 memory / memory-mapped I/O
// controller (mem_io_ctrl and its io_regs sub-module).
//   - Device register addresses (KBSR, KBDR, DSR, DDR).
//   - Controller state enum and decoded access-target enum.
//   - decode_addr(): maps a 16-bit address to its access target.
// Optional feature macro used by the including files: MEM_IO_KBIE_EN.

package mem_io_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        DRAIN
    } mem_io_state_t;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_KBSR,
        SEL_KBDR,
        SEL_DSR,
        SEL_DDR
    } io_sel_t;

    // Only the four exact device addresses are I/O; everything else,
    // including the rest of the xFE08-xFFFF page, is plain RAM.
    function automatic io_sel_t decode_addr(input logic [15:0] addr);
        case (addr)
            KBSR_ADDR: return SEL_KBSR;
            KBDR_ADDR: return SEL_KBDR;
            DSR_ADDR:  return SEL_DSR;
            DDR_ADDR:  return SEL_DDR;
            default:   return SEL_RAM;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_ctrl_io_regs.sv
// io_regs: keyboard and display device registers for mem_io_ctrl.
// Holds KBSR/KBDR/DSR/DDR, the keyboard and display byte handshakes and the
// keyboard interrupt. Read/write strobes arrive already qualified by the
// controller FSM (one cycle, on the edge that completes the access).
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sel                 decoded target of the current access
//   rd_en / wr_en       access-complete strobes for a read / write
//   wr_ie, wr_byte      write data bit 14 and low byte
//   rdata               zero-extended register read value (combinational)
//   kb_valid/kb_data/kb_ack        keyboard byte handshake
//   disp_valid/disp_data/disp_ready display byte handshake
//   kb_irq              keyboard interrupt
// Macro MEM_IO_KBIE_EN: when defined KBSR[14] is writable and kb_irq is
// the registered KBSR[15] & KBSR[14]; otherwise KBSR[14] reads 0, and
// kb_irq is tied low.

module io_regs
    import mem_io_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  io_sel_t     sel,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        wr_ie,
    input  logic [7:0]  wr_byte,
    output logic [15:0] rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ack,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq
);

    logic       kbsr_rdy_q, kbsr_rdy_d;
    logic [7:0] kbdr_q, kbdr_d;
    logic       dsr_rdy_q, dsr_rdy_d;
    logic       disp_valid_q, disp_valid_d;
    logic [7:0] disp_data_q, disp_data_d;
    logic       kb_ack_q, kb_ack_d;
    logic       kbsr_ie_q;
    logic       kbdr_clr;

    assign kbdr_clr = rd_en && (sel == SEL_KBDR);

    always_comb begin
        kbsr_rdy_d   = kbsr_rdy_q;
        kbdr_d       = kbdr_q;
        dsr_rdy_d    = dsr_rdy_q;
        disp_valid_d = disp_valid_q;
        disp_data_d  = disp_data_q;
        kb_ack_d     = 1'b0;

        // A KBDR read clearing the ready bit blocks capture on the same
        // edge, so the new byte waits one cycle instead of being lost.
        if (!kbsr_rdy_q && kb_valid && !kbdr_clr) begin
            kbdr_d     = kb_data;
            kbsr_rdy_d = 1'b1;
            kb_ack_d   = 1'b1;
        end
        if (kbdr_clr) begin
            kbsr_rdy_d = 1'b0;
        end

        // DDR writes while the display is busy are silently dropped.
        if (wr_en && (sel == SEL_DDR) && dsr_rdy_q) begin
            disp_data_d  = wr_byte;
            dsr_rdy_d    = 1'b0;
            disp_valid_d = 1'b1;
        end
        if (disp_valid_q && disp_ready) begin
            disp_valid_d = 1'b0;
            dsr_rdy_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kbsr_rdy_q   <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_rdy_q    <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
            kb_ack_q     <= 1'b0;
        end else begin
            kbsr_rdy_q   <= kbsr_rdy_d;
            kbdr_q       <= kbdr_d;
            dsr_rdy_q    <= dsr_rdy_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
            kb_ack_q     <= kb_ack_d;
        end
    end

`ifdef MEM_IO_KBIE_EN
    logic kbsr_ie_d;
    logic kb_irq_q, kb_irq_d;

    always_comb begin
        kbsr_ie_d = kbsr_ie_q;
        if (wr_en && (sel == SEL_KBSR)) begin
            kbsr_ie_d = wr_ie;
        end
        kb_irq_d = kbsr_rdy_q & kbsr_ie_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kbsr_ie_q <= 1'b0;
            kb_irq_q  <= 1'b0;
        end else begin
            kbsr_ie_q <= kbsr_ie_d;
            kb_irq_q  <= kb_irq_d;
        end
    end

    assign kb_irq = kb_irq_q;
`else
    logic unused_wr_ie;
    assign unused_wr_ie = wr_ie;
    assign kbsr_ie_q    = 1'b0;
    assign kb_irq       = 1'b0;
`endif

    always_comb begin
        rdata = 16'h0000;
        case (sel)
            SEL_KBSR: rdata = {kbsr_rdy_q, kbsr_ie_q, 14'h0000};
            SEL_KBDR: rdata = {8'h00, kbdr_q};
            SEL_DSR:  rdata = {dsr_rdy_q, 15'h0000};
            SEL_DDR:  rdata = {8'h00, disp_data_q};
            default:  rdata = 16'h0000;
        endcase
    end

    assign kb_ack     = kb_ack_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: LC-3 memory and memory-mapped I/O controller.
// Takes the control FSM's CS/WE request, routes it to the RAM array or to
// the keyboard/display registers (io_regs), and returns read data with a
// one-cycle ready pulse LATENCY+1 edges after the request edge.
// Ports:
//   CLK, RST                 system clock, synchronous active-high reset
//   CS, WE, ADDR, DataIn     access request (held until ready), from MAR/MDR
//   out, ready               read data to MEM_MUX and the R signal
//   ram_addr/ram_din/ram_we  RAM array port; ram_dout is its registered read
//   kb_valid/kb_data/kb_ack  keyboard byte handshake
//   disp_valid/disp_data/disp_ready display byte handshake
//   kb_irq                   keyboard interrupt
// Parameter LATENCY (>= 1): wait count of the BUSY state.
// Macro MEM_IO_KBIE_EN: enables the KBSR interrupt-enable bit and kb_irq.

module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CS,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DataIn,
    output logic [15:0] out,
    output logic        ready,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ack,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        kb_irq
);

    localparam int               CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    mem_io_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [15:0]      out_q, out_d;
    logic             ram_we_q, ram_we_d;

    io_sel_t     sel;
    logic        access_end;
    logic [15:0] io_rdata;

    assign sel        = decode_addr(addr_q);
    assign access_end = (state_q == BUSY) && (cnt_q == CNT_LAST);

    // NOTE: every signal written here is given its default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        out_d    = out_q;
        ram_we_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (CS) begin
                    state_d  = BUSY;
                    addr_d   = ADDR;
                    wdata_d  = DataIn;
                    we_d     = WE;
                    cnt_d    = '0;
                    // Single write pulse, aligned with the first BUSY cycle.
                    ram_we_d = WE && (decode_addr(ADDR) == SEL_RAM);
                end
            end
            BUSY: begin
                if (access_end) begin
                    state_d = DONE;
                    if (!we_q) begin
                        out_d = (sel == SEL_RAM) ? ram_dout : io_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = DRAIN;
            // Waiting for CS to drop keeps a held request from re-firing.
            DRAIN:   if (!CS) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            we_q     <= 1'b0;
            out_q    <= 16'h0000;
            ram_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            out_q    <= out_d;
            ram_we_q <= ram_we_d;
        end
    end

    io_regs u_io_regs (
        .clk        (CLK),
        .rst        (RST),
        .sel        (sel),
        .rd_en      (access_end && !we_q),
        .wr_en      (access_end && we_q),
        .wr_ie      (wdata_q[14]),
        .wr_byte    (wdata_q[7:0]),
        .rdata      (io_rdata),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ack     (kb_ack),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready),
        .kb_irq     (kb_irq)
    );

    assign out      = out_q;
    assign ready    = (state_q == DONE);
    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;
    assign ram_we   = ram_we_q;

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory and memory-mapped I/O controller between the LC-3 datapath's MAR/MDR/MEM_MUX path and the main RAM array. Accepts the FSM's CS/WE access request, routes it to RAM or to the keyboard/display device registers, and returns read data plus a one-cycle `ready` pulse after a fixed, parameterised latency. This produces the `R` signal that the memory-access states of the control FSM wait on.

## Interface
- `LATENCY`, default 2: wait cycles per access (≥1).
- `CLK` input 1: system clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `CS` input 1: access request (MIO_EN), level, held by the FSM until `ready`.
- `WE` input 1: 1 = write, 0 = read; sampled with `CS`.
- `ADDR` input 16: access address (MARout).
- `DataIn` input 16: write data (MDRout).
- `out` output 16: read data (feeds MEM_MUX in1).
- `ready` output 1: access complete, one-cycle pulse.
- `ram_addr` output 16, `ram_din` output 16, `ram_we` output 1: RAM array port.
- `ram_dout` input 16: RAM read data, valid one cycle after `ram_addr`.
- `kb_valid` input 1, `kb_data` input 8, `kb_ack` output 1: keyboard byte handshake.
- `disp_valid` output 1, `disp_data` output 8, `disp_ready` input 1: display byte handshake.
- `kb_irq` output 1: keyboard interrupt (macro-dependent).

## Operation
- Address map (decoded from the latched address):
  - xFE00 KBSR: [15] ready, [14] IE.
  - xFE02 KBDR: [7:0] byte.
  - xFE04 DSR: [15] ready.
  - xFE06 DDR: [7:0] byte.
  - All other addresses, including xFE08–xFFFF, go to RAM.
- FSM states:
  - IDLE → BUSY when `CS`=1. ADDR, WE and DataIn are latched at that edge.
  - BUSY counts LATENCY cycles, then → DONE.
  - DONE drives `ready`=1 for one cycle, then → DRAIN.
  - DRAIN → IDLE when `CS`=0. Holding `CS` high never starts a second access.
- RAM access: `ram_addr` holds the latched address during BUSY.
  - Write: `ram_we` is pulsed for exactly one cycle, on the first BUSY cycle.
  - Read: `ram_dout` is registered into `out` on the edge that enters DONE.
- I/O read: the register value is zero-extended into `out`. Reading KBDR clears KBSR[15] on the DONE edge.
- I/O write:
  - KBSR: only bit 14 is written.
  - KBDR and DSR: ignored.
  - DDR when DSR[15]=1: loads `disp_data`, clears DSR[15], sets `disp_valid`.
  - DDR when DSR[15]=0: write is dropped; `ready` is still returned.
- Keyboard capture: when KBSR[15]=0 and `kb_valid`=1:
  - KBDR ← `kb_data`.
  - KBSR[15] ← 1.
  - `kb_ack`=1 for one cycle.
- Display completion: when `disp_valid`=1 and `disp_ready`=1, at that edge `disp_valid` ← 0 and DSR[15] ← 1.
- Simultaneous KBDR read clear and new keyboard byte: the clear wins. The byte is captured on the next cycle; `kb_ack` is withheld until then.
- `out` holds its value until the next read completes.

## Timing
- Reset values:
  - State: IDLE.
  - `out`=0, `ready`=0, `ram_we`=0, `ram_addr`=0.
  - KBSR=0, KBDR=0, DSR=x8000.
  - `disp_valid`=0, `disp_data`=0, `kb_ack`=0, `kb_irq`=0.
- Latency: request sampled at edge t0. `ready` is high in the cycle following edge t0+LATENCY+1 (LATENCY=2 → 3 edges).
- Reset mid-access aborts it: no `ready`, and no further RAM write beyond one already issued.
- `CS` dropped during BUSY does not abort the access. `ready` is still pulsed, then DRAIN exits immediately.

## Configuration
- `MEM_IO_KBIE_EN` defined: KBSR[14] is writable and `kb_irq` = KBSR[15] & KBSR[14], registered.
- Not defined: KBSR[14] reads 0, writes to it are ignored, and `kb_irq` is tied to 0.

## Structure
- Package `mem_io_pkg` holds:
  - Address constants `KBSR_ADDR`, `KBDR_ADDR`, `DSR_ADDR`, `DDR_ADDR`.
  - State enum `mem_io_state_t` (IDLE, BUSY, DONE, DRAIN).
- Sub-module `io_regs` holds KBSR/KBDR/DSR/DDR, both device handshakes and `kb_irq`. It receives decoded read/write strobes from the top-level FSM.

## Test plan
- RAM write x3000←x1234, then read x3000 with LATENCY=2 → `ready` 3 edges after `CS`, `out`=x1234, exactly one `ram_we` pulse.
- `CS` held high for 10 cycles → exactly one `ready` pulse; next access starts only after `CS` goes low.
- `kb_valid`=1, `kb_data`=x41 → `kb_ack` pulse; read xFE00 gives x8000; read xFE02 gives x0041, then KBSR reads x0000.
- Write xFE06←x0058 → `disp_valid`=1, `disp_data`=x58, DSR=x0000. A second DDR write before `disp_ready` is dropped. `disp_ready`=1 → DSR=x8000.
- With `MEM_IO_KBIE_EN`: write xFE00←x4000, then a key arrives → `kb_irq`=1. Without the macro: `kb_irq` stays 0 and KBSR reads x8000.
- `RST` asserted during BUSY of a read → no `ready`, state IDLE, and all outputs at their reset values next cycle.
